// File: rtl/core_quant_pkg.sv
// Shared types and width helpers for the MAC/requantise datapath.
// Also holds the saturating clamp reused by later vector blocks.
package core_quant_pkg;

  localparam int CDATA_ACCU_NUM_WIDTH = 8;
  localparam int CDATA_SCALE_WIDTH    = 16;
  localparam int CDATA_BIAS_WIDTH     = 16;
  localparam int CDATA_SHIFT_WIDTH    = 5;

  typedef struct packed {
    logic [CDATA_ACCU_NUM_WIDTH-1:0]     acc_num;
    logic signed [CDATA_SCALE_WIDTH-1:0] scale;
    logic signed [CDATA_BIAS_WIDTH-1:0]  bias;
    logic [CDATA_SHIFT_WIDTH-1:0]        shift;
  } quant_cfg_t;

  localparam quant_cfg_t QUANT_CFG_RESET = '{
    acc_num: CDATA_ACCU_NUM_WIDTH'(1),
    scale:   CDATA_SCALE_WIDTH'(1),
    bias:    '0,
    shift:   '0
  };

  function automatic int acc_w(input int idata_w, input int mult_num);
    return 2 * idata_w + $clog2(mult_num) + CDATA_ACCU_NUM_WIDTH;
  endfunction

  function automatic int q_w(input int acc_width);
    return acc_width + CDATA_SCALE_WIDTH + 1;
  endfunction

  // Clamp a sign-extended value into the signed range of an obit-wide result.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] val,
                                                   input int obit);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (obit - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (obit - 1));
    if (val > hi) return hi;
    if (val < lo) return lo;
    return val;
  endfunction

endpackage

// File: rtl/core_mac_quant_mc_if.sv
// Beat input and result output handshake bundle for core_mac_quant_mc.
interface core_mac_quant_mc_if #(
  parameter int MAC_MULT_NUM = 16,
  parameter int IDATA_WIDTH  = 8,
  parameter int ODATA_BIT    = 8,
  parameter int CH_W         = 1
);
  logic                                  in_vld;
  logic                                  in_rdy;
  logic [CH_W-1:0]                       in_ch;
  logic [MAC_MULT_NUM*IDATA_WIDTH-1:0]   in_act;
  logic [MAC_MULT_NUM*IDATA_WIDTH-1:0]   in_wgt;
  logic                                  out_vld;
  logic                                  out_rdy;
  logic signed [ODATA_BIT-1:0]           out_data;
  logic [CH_W-1:0]                       out_ch;

  modport master (
    output in_vld, in_ch, in_act, in_wgt, out_rdy,
    input  in_rdy, out_vld, out_data, out_ch
  );

  modport slave (
    input  in_vld, in_ch, in_act, in_wgt, out_rdy,
    output in_rdy, out_vld, out_data, out_ch
  );
endinterface

// File: rtl/core_quant_rnd_sat.sv
// Combinational requantiser: acc*scale + bias, arithmetic shift with round-half-up,
// then clamp to the signed output range with a saturation flag.
module core_quant_rnd_sat
  import core_quant_pkg::*;
#(
  parameter int ACC_W     = 28,
  parameter int ODATA_BIT = 8
) (
  input  logic signed [ACC_W-1:0]     acc_i,
  input  quant_cfg_t                  cfg_i,
  output logic signed [ODATA_BIT-1:0] data_o,
  output logic                        sat_o
);
  localparam int Q_W = q_w(ACC_W);

  logic signed [Q_W-1:0] q;
  logic signed [Q_W-1:0] q_sh;
  logic signed [Q_W-1:0] r;
  logic signed [63:0]    r_ext;
  logic signed [63:0]    r_clamp;
  logic                  rnd;

  always_comb begin
    q       = Q_W'(acc_i) * Q_W'($signed(cfg_i.scale)) + Q_W'($signed(cfg_i.bias));
    q_sh    = q >>> cfg_i.shift;
    // The rounding bit is the last bit shifted out, i.e. q[shift-1].
    rnd     = (cfg_i.shift != '0) &&
              (((q >>> (cfg_i.shift - CDATA_SHIFT_WIDTH'(1))) & Q_W'(1)) != '0);
    r       = q_sh + Q_W'(rnd);
    r_ext   = 64'(r);
    r_clamp = sat_clamp(r_ext, ODATA_BIT);
    data_o  = ODATA_BIT'(r_clamp);
    sat_o   = (r_clamp != r_ext);
  end

endmodule

// File: rtl/core_mac_quant_mc.sv
// Multi-channel MAC/accumulate/requantise unit: S1 lane products, S2 adder tree and
// per-channel accumulate, S3 requantise, then a small result FIFO with credit-based in_rdy.
module core_mac_quant_mc
  import core_quant_pkg::*;
#(
  parameter int MAC_MULT_NUM   = 16,
  parameter int IDATA_WIDTH    = 8,
  parameter int ODATA_BIT      = 8,
  parameter int NUM_CH         = 2,
  parameter int OUT_FIFO_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                cfg_vld,
  input  logic [CDATA_ACCU_NUM_WIDTH-1:0]     cfg_acc_num,
  input  logic signed [CDATA_SCALE_WIDTH-1:0] cfg_quant_scale,
  input  logic signed [CDATA_BIAS_WIDTH-1:0]  cfg_quant_bias,
  input  logic [CDATA_SHIFT_WIDTH-1:0]        cfg_quant_shift,
  output logic                                cfg_err,
  core_mac_quant_mc_if.slave                  bus,
  output logic [15:0]                         sat_cnt
);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PROD_W = 2 * IDATA_WIDTH;
  localparam int ACC_W  = acc_w(IDATA_WIDTH, MAC_MULT_NUM);
  localparam int PTR_W  = $clog2(OUT_FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  quant_cfg_t cfg_q;
  logic       cfg_err_q;
  logic [15:0] sat_cnt_q;
  logic       beat_acc;

  logic                     s1_vld_q;
  logic [CH_W-1:0]          s1_ch_q;
  logic signed [PROD_W-1:0] s1_prod_q [MAC_MULT_NUM];

  logic signed [ACC_W-1:0]          acc_q [NUM_CH];
  logic [CDATA_ACCU_NUM_WIDTH-1:0]  cnt_q [NUM_CH];
  logic signed [ACC_W-1:0]          lane_sum;
  logic signed [ACC_W-1:0]          grp_sum;
  logic [CDATA_ACCU_NUM_WIDTH-1:0]  last_idx;
  logic                             grp_last;
  logic                             s2_vld_q;
  logic [CH_W-1:0]                  s2_ch_q;
  logic signed [ACC_W-1:0]          s2_sum_q;

  logic signed [ODATA_BIT-1:0] q_data;
  logic                        q_sat;
  logic                        s3_vld_q;
  logic [CH_W-1:0]             s3_ch_q;
  logic signed [ODATA_BIT-1:0] s3_data_q;

  logic signed [ODATA_BIT-1:0] fifo_data_q [OUT_FIFO_DEPTH];
  logic [CH_W-1:0]             fifo_ch_q   [OUT_FIFO_DEPTH];
  logic [PTR_W-1:0]            wr_ptr_q;
  logic [PTR_W-1:0]            rd_ptr_q;
  logic [CNT_W-1:0]            fifo_cnt_q;
  logic [CNT_W-1:0]            fifo_cnt_d;
  logic                        push;
  logic                        pop;
  logic [CNT_W:0]              credit_used;
  logic                        cnt_busy;
  logic                        idle;

  assign beat_acc = bus.in_vld && bus.in_rdy;

  // S1: one registered product per lane.
  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_vld_q <= 1'b0;
      s1_ch_q  <= '0;
      for (int k = 0; k < MAC_MULT_NUM; k++) s1_prod_q[k] <= '0;
    end else begin
      s1_vld_q <= beat_acc;
      if (beat_acc) begin
        s1_ch_q <= bus.in_ch;
        for (int k = 0; k < MAC_MULT_NUM; k++)
          s1_prod_q[k] <= $signed(bus.in_act[k*IDATA_WIDTH +: IDATA_WIDTH]) *
                          $signed(bus.in_wgt[k*IDATA_WIDTH +: IDATA_WIDTH]);
      end
    end
  end

  // NOTE: every always_comb output gets a value before any branch, so no latch can form.
  always_comb begin
    lane_sum = '0;
    for (int k = 0; k < MAC_MULT_NUM; k++) lane_sum = lane_sum + ACC_W'(s1_prod_q[k]);
    grp_sum  = acc_q[s1_ch_q] + lane_sum;
    last_idx = (cfg_q.acc_num == '0) ? '0 : cfg_q.acc_num - CDATA_ACCU_NUM_WIDTH'(1);
    grp_last = (cnt_q[s1_ch_q] == last_idx);
  end

  // S2: a closing beat hands the full sum to S3 and rearms its channel.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_vld_q <= 1'b0;
      s2_ch_q  <= '0;
      s2_sum_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c] <= '0;
        cnt_q[c] <= '0;
      end
    end else begin
      s2_vld_q <= s1_vld_q && grp_last;
      if (s1_vld_q) begin
        if (grp_last) begin
          s2_sum_q         <= grp_sum;
          s2_ch_q          <= s1_ch_q;
          acc_q[s1_ch_q]   <= '0;
          cnt_q[s1_ch_q]   <= '0;
        end else begin
          acc_q[s1_ch_q]   <= grp_sum;
          cnt_q[s1_ch_q]   <= cnt_q[s1_ch_q] + CDATA_ACCU_NUM_WIDTH'(1);
        end
      end
    end
  end

  core_quant_rnd_sat #(
    .ACC_W     (ACC_W),
    .ODATA_BIT (ODATA_BIT)
  ) u_rnd_sat (
    .acc_i  (s2_sum_q),
    .cfg_i  (cfg_q),
    .data_o (q_data),
    .sat_o  (q_sat)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s3_vld_q  <= 1'b0;
      s3_ch_q   <= '0;
      s3_data_q <= '0;
      sat_cnt_q <= '0;
    end else begin
      s3_vld_q <= s2_vld_q;
      if (s2_vld_q) begin
        s3_data_q <= q_data;
        s3_ch_q   <= s2_ch_q;
        if (q_sat && sat_cnt_q != 16'hFFFF) sat_cnt_q <= sat_cnt_q + 16'd1;
      end
    end
  end

  assign push = s3_vld_q;
  assign pop  = bus.out_vld && bus.out_rdy;

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    if (push && !pop)      fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
    else if (!push && pop) fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
  end

  // NOTE: the result array is reset too, so out_data reads 0 rather than stale data after reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      for (int i = 0; i < OUT_FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_ch_q[i]   <= '0;
      end
    end else begin
      fifo_cnt_q <= fifo_cnt_d;
      if (push) begin
        fifo_data_q[wr_ptr_q] <= s3_data_q;
        fifo_ch_q[wr_ptr_q]   <= s3_ch_q;
        wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  assign bus.out_vld  = (fifo_cnt_q != '0);
  assign bus.out_data = fifo_data_q[rd_ptr_q];
  assign bus.out_ch   = fifo_ch_q[rd_ptr_q];

  // Any beat in S1 might close a group, so it reserves a FIFO slot like S2/S3 results.
  assign credit_used = (CNT_W+1)'(fifo_cnt_q) + (CNT_W+1)'(s1_vld_q) +
                       (CNT_W+1)'(s2_vld_q) + (CNT_W+1)'(s3_vld_q);
  assign bus.in_rdy  = (credit_used < (CNT_W+1)'(OUT_FIFO_DEPTH));

  always_comb begin
    cnt_busy = 1'b0;
    for (int c = 0; c < NUM_CH; c++) if (cnt_q[c] != '0) cnt_busy = 1'b1;
    idle = !cnt_busy && !s1_vld_q && !s2_vld_q && !s3_vld_q &&
           (fifo_cnt_q == '0) && !beat_acc;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cfg_q     <= QUANT_CFG_RESET;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_vld && !idle;
      if (cfg_vld && idle)
        cfg_q <= '{acc_num: cfg_acc_num, scale: cfg_quant_scale,
                   bias: cfg_quant_bias, shift: cfg_quant_shift};
    end
  end

  assign cfg_err = cfg_err_q;
  assign sat_cnt = sat_cnt_q;

endmodule

// File: tb/tb_core_mac_quant_mc.sv
// Directed bench for core_mac_quant_mc with hand-computed expected results.
module tb_core_mac_quant_mc;
  import core_quant_pkg::*;

  localparam int LANES = 16;
  localparam int IW    = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic                                cfg_vld = 1'b0;
  logic [CDATA_ACCU_NUM_WIDTH-1:0]     cfg_acc_num = '0;
  logic signed [CDATA_SCALE_WIDTH-1:0] cfg_quant_scale = '0;
  logic signed [CDATA_BIAS_WIDTH-1:0]  cfg_quant_bias = '0;
  logic [CDATA_SHIFT_WIDTH-1:0]        cfg_quant_shift = '0;
  logic                                cfg_err;
  logic [15:0]                         sat_cnt;

  int checks = 0;
  int errors = 0;
  int n;
  int sent;
  int rcvd;

  always #5 clk = ~clk;

  core_mac_quant_mc_if bus ();

  core_mac_quant_mc dut (
    .clk             (clk),
    .rstn            (rstn),
    .cfg_vld         (cfg_vld),
    .cfg_acc_num     (cfg_acc_num),
    .cfg_quant_scale (cfg_quant_scale),
    .cfg_quant_bias  (cfg_quant_bias),
    .cfg_quant_shift (cfg_quant_shift),
    .cfg_err         (cfg_err),
    .bus             (bus),
    .sat_cnt         (sat_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive_lanes(input int act, input int wgt, input int nl);
    for (int k = 0; k < LANES; k++) begin
      bus.in_act[k*IW +: IW] = (k < nl) ? IW'(act) : IW'(0);
      bus.in_wgt[k*IW +: IW] = (k < nl) ? IW'(wgt) : IW'(0);
    end
  endtask

  task automatic send_beat(input int ch, input int act, input int wgt, input int nl);
    int w;
    w = 0;
    bus.in_ch  = 1'(ch);
    drive_lanes(act, wgt, nl);
    bus.in_vld = 1'b1;
    while (!bus.in_rdy && w < 50) begin
      tick;
      w++;
    end
    if (!bus.in_rdy) check("in_rdy_timeout", 32'(bus.in_rdy), 1);
    tick;
    bus.in_vld = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!bus.out_vld && cyc < 30) begin
      tick;
      cyc++;
    end
    if (!bus.out_vld) check("out_vld_timeout", 32'(bus.out_vld), 1);
  endtask

  task automatic pop;
    bus.out_rdy = 1'b1;
    tick;
    bus.out_rdy = 1'b0;
  endtask

  task automatic expect_result(input string tag, input int data, input int ch);
    int cyc;
    wait_out(cyc);
    check({tag, "_data"}, bus.out_data, data);
    check({tag, "_ch"}, 32'(bus.out_ch), ch);
    pop;
  endtask

  task automatic apply_cfg(input int acc_num, input int scale, input int bias,
                           input int shift, input int exp_err);
    cfg_acc_num     = CDATA_ACCU_NUM_WIDTH'(acc_num);
    cfg_quant_scale = CDATA_SCALE_WIDTH'(scale);
    cfg_quant_bias  = CDATA_BIAS_WIDTH'(bias);
    cfg_quant_shift = CDATA_SHIFT_WIDTH'(shift);
    cfg_vld = 1'b1;
    tick;
    cfg_vld = 1'b0;
    check("cfg_err", 32'(cfg_err), exp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_vld  = 1'b0;
    bus.in_ch   = '0;
    bus.in_act  = '0;
    bus.in_wgt  = '0;
    bus.out_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_vld", 32'(bus.out_vld), 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_ch", 32'(bus.out_ch), 0);
    check("rst_cfg_err", 32'(cfg_err), 0);
    check("rst_sat_cnt", 32'(sat_cnt), 0);
    rstn = 1'b1;
    tick;
    check("rst_in_rdy", 32'(bus.in_rdy), 1);

    // 1: four all-ones beats on ch0, shift 1 -> 64/2 = 32, three-cycle latency
    apply_cfg(4, 1, 0, 1, 0);
    repeat (4) send_beat(0, 1, 1, LANES);
    wait_out(n);
    check("t1_latency", n, 3);
    check("t1_data", bus.out_data, 32);
    check("t1_ch", 32'(bus.out_ch), 0);
    check("t1_sat_cnt", 32'(sat_cnt), 0);
    pop;
    check("t1_drained", 32'(bus.out_vld), 0);

    // 2: round half up on lane 0, plus negative scale with bias
    apply_cfg(1, 1, 0, 1, 0);
    send_beat(0, 1, 3, 1);
    expect_result("t2_p3", 2, 0);
    send_beat(0, -1, 3, 1);
    expect_result("t2_m3", -1, 0);
    send_beat(0, 1, 2, 1);
    expect_result("t2_p2", 1, 0);
    apply_cfg(1, -3, 10, 2, 0);
    send_beat(0, 5, 1, 1);
    expect_result("t2_bias", -1, 0);

    // 3: saturation at both ends
    apply_cfg(1, 1, 0, 0, 0);
    send_beat(0, 127, 127, LANES);
    expect_result("t3_hi", 127, 0);
    send_beat(0, -128, 127, LANES);
    expect_result("t3_lo", -128, 0);
    check("t3_sat_cnt", 32'(sat_cnt), 2);

    // 4: interleaved channels, results in completion order, data held under stall
    apply_cfg(2, 1, 0, 0, 0);
    send_beat(0, 1, 5, 1);
    send_beat(1, 2, 5, 1);
    send_beat(0, 1, 5, 1);
    send_beat(1, 2, 5, 1);
    wait_out(n);
    check("t4_ch0_data", bus.out_data, 10);
    check("t4_ch0_ch", 32'(bus.out_ch), 0);
    tick;
    tick;
    check("t4_hold_data", bus.out_data, 10);
    check("t4_hold_ch", 32'(bus.out_ch), 0);
    pop;
    expect_result("t4_ch1", 20, 1);

    // 5: backpressure: credit stops intake at 4 outstanding, then ordered drain
    apply_cfg(1, 1, 0, 0, 0);
    sent = 0;
    rcvd = 0;
    bus.in_ch   = '0;
    bus.out_rdy = 1'b0;
    for (int c = 0; c < 20; c++) begin
      bus.in_vld = (sent < 10);
      drive_lanes(sent + 1, 1, 1);
      if (bus.in_vld && bus.in_rdy) sent++;
      tick;
    end
    check("t5_sent_stalled", sent, 4);
    check("t5_in_rdy_low", 32'(bus.in_rdy), 0);
    check("t5_out_vld", 32'(bus.out_vld), 1);
    bus.out_rdy = 1'b1;
    for (int c = 0; c < 200 && rcvd < 10; c++) begin
      if (bus.out_vld) begin
        check("t5_order", bus.out_data, rcvd + 1);
        rcvd++;
      end
      bus.in_vld = (sent < 10);
      drive_lanes(sent + 1, 1, 1);
      if (bus.in_vld && bus.in_rdy) sent++;
      tick;
    end
    bus.in_vld  = 1'b0;
    bus.out_rdy = 1'b0;
    check("t5_count", rcvd, 10);
    tick;
    tick;
    check("t5_no_dup", 32'(bus.out_vld), 0);

    // 6a: config while mid-group is rejected and the old config stays in force
    apply_cfg(4, 1, 0, 0, 0);
    send_beat(0, 1, 1, 1);
    send_beat(0, 1, 1, 1);
    apply_cfg(1, 1, 0, 3, 1);
    tick;
    check("t6_err_pulse_end", 32'(cfg_err), 0);
    send_beat(0, 1, 1, 1);
    send_beat(0, 1, 1, 1);
    wait_out(n);
    check("t6_old_cfg_data", bus.out_data, 4);

    // 6b: reset with a partial group and a queued result
    send_beat(0, 1, 1, 1);
    send_beat(0, 1, 1, 1);
    rstn = 1'b0;
    #1;
    check("t6_rst_out_vld", 32'(bus.out_vld), 0);
    check("t6_rst_out_data", bus.out_data, 0);
    check("t6_rst_sat_cnt", 32'(sat_cnt), 0);
    check("t6_rst_cfg_err", 32'(cfg_err), 0);
    tick;
    rstn = 1'b1;
    tick;
    check("t6_rst_in_rdy", 32'(bus.in_rdy), 1);
    send_beat(0, 3, 1, 1);
    expect_result("t6_default_cfg", 3, 0);
    apply_cfg(4, 1, 0, 0, 0);
    repeat (4) send_beat(0, 2, 1, 1);
    expect_result("t6_fresh", 8, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
